dmem_arbiter: RTL and testbench

- Two-port arbiter sharing the single-port 64-word data memory between the CPU load/store path (port 0) and a debug/DMA requester (port 1).
- One access granted per cycle, chosen by round-robin.
- Optional short lock lets one port perform an atomic read-modify-write.
- Drives the memory's read-enable, write-enable, address and write-data. Returns registered read data with a valid pulse.

---
 rtl/dmem_arbiter.sv | 116 +++++++++++
 tb/tb_dmem_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter for a shared single-port 64-word data memory, with a short RMW lock.
// Optional grant/conflict statistics counters are enabled by DMEM_ARB_STATS_EN.
module dmem_arbiter #(
   parameter int AW       = 6,
   parameter int DW       = 32,
   parameter int LOCK_MAX = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          p0_req,
   input  logic          p0_we,
   input  logic          p0_lock,
   input  logic [AW-1:0] p0_addr,
   input  logic [DW-1:0] p0_wdata,
   output logic          p0_gnt,
   output logic          p0_rvalid,
   output logic [DW-1:0] p0_rdata,
   input  logic          p1_req,
   input  logic          p1_we,
   input  logic          p1_lock,
   input  logic [AW-1:0] p1_addr,
   input  logic [DW-1:0] p1_wdata,
   output logic          p1_gnt,
   output logic          p1_rvalid,
   output logic [DW-1:0] p1_rdata,
   output logic          mem_read,
   output logic          mem_write,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
   ,
   output logic [15:0]   stat_gnt0,
   output logic [15:0]   stat_gnt1,
   output logic [15:0]   stat_conflict
`endif
);
   typedef enum logic [1:0] {RR, LOCK0, LOCK1} state_e;
   state_e        state_q, state_d;
   logic          rr_q, rr_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          lk0, lk1;
   logic          rv0_q, rv1_q;
   logic [DW-1:0] rd0_q, rd1_q;

   // A lock only holds priority while its owner keeps requesting; otherwise plain round-robin applies.
   always_comb begin
      lk0     = state_q == LOCK0 && p0_req;
      lk1     = state_q == LOCK1 && p1_req;
      p0_gnt  = p0_req && !lk1 && (lk0 || !p1_req || !rr_q);
      p1_gnt  = p1_req && !p0_gnt && !lk0;
      state_d = RR;
      rr_d    = rr_q;
      cnt_d   = '0;
      if (lk0 || lk1) begin
         if ((lk0 ? p0_lock : p1_lock) && cnt_q < 4'(LOCK_MAX - 1)) begin
            state_d = state_q;
            cnt_d   = cnt_q + 4'd1;
         end else
            rr_d = lk0;
      end else if (p0_gnt || p1_gnt) begin
         rr_d = p0_gnt;
         if (LOCK_MAX > 1 && (p0_gnt ? p0_lock : p1_lock)) begin
            state_d = p0_gnt ? LOCK0 : LOCK1;
            cnt_d   = 4'd1;
         end
      end
   end

   assign mem_addr  = p0_gnt ? p0_addr  : p1_gnt ? p1_addr  : '0;
   assign mem_wdata = p0_gnt ? p0_wdata : p1_gnt ? p1_wdata : '0;
   assign mem_read  = (p0_gnt && !p0_we) || (p1_gnt && !p1_we);
   assign mem_write = (p0_gnt && p0_we) || (p1_gnt && p1_we);
   assign p0_rvalid = rv0_q;
   assign p1_rvalid = rv1_q;
   assign p0_rdata  = rd0_q;
   assign p1_rdata  = rd1_q;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= RR;
         rr_q    <= 1'b0;
         cnt_q   <= '0;
         rv0_q   <= 1'b0;
         rv1_q   <= 1'b0;
         rd0_q   <= '0;
         rd1_q   <= '0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         cnt_q   <= cnt_d;
         rv0_q   <= p0_gnt && !p0_we;
         rv1_q   <= p1_gnt && !p1_we;
         if (p0_gnt && !p0_we) rd0_q <= mem_rdata;
         if (p1_gnt && !p1_we) rd1_q <= mem_rdata;
      end

`ifdef DMEM_ARB_STATS_EN
   logic [15:0] gnt0_q, gnt1_q, conf_q;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         gnt0_q <= '0;
         gnt1_q <= '0;
         conf_q <= '0;
      end else begin
         if (p0_gnt && gnt0_q != 16'hFFFF) gnt0_q <= gnt0_q + 16'd1;
         if (p1_gnt && gnt1_q != 16'hFFFF) gnt1_q <= gnt1_q + 16'd1;
         if (p0_req && p1_req && conf_q != 16'hFFFF) conf_q <= conf_q + 16'd1;
      end

   assign stat_gnt0     = gnt0_q;
   assign stat_gnt1     = gnt1_q;
   assign stat_conflict = conf_q;
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed plan scenarios plus held-until-granted random traffic, checked against a
// behavioural model of the arbitration rules with a shadow memory.
module tb_dmem_arbiter;
   localparam int AW = 6;
   localparam int DW = 32;
   localparam int LM = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          p0_req = 0, p0_we = 0, p0_lock = 0, p1_req = 0, p1_we = 0, p1_lock = 0;
   logic [AW-1:0] p0_addr = '0, p1_addr = '0;
   logic [DW-1:0] p0_wdata = '0, p1_wdata = '0;
   logic          p0_gnt, p0_rvalid, p1_gnt, p1_rvalid, mem_read, mem_write;
   logic [DW-1:0] p0_rdata, p1_rdata, mem_wdata, mem_rdata;
   logic [AW-1:0] mem_addr;
`ifdef DMEM_ARB_STATS_EN
   logic [15:0]   stat_gnt0, stat_gnt1, stat_conflict;
`endif

   dmem_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(LM)) dut (
      .clk(clk), .rst_n(rst_n),
      .p0_req(p0_req), .p0_we(p0_we), .p0_lock(p0_lock), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
      .p1_req(p1_req), .p1_we(p1_we), .p1_lock(p1_lock), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_STATS_EN
      , .stat_gnt0(stat_gnt0), .stat_gnt1(stat_gnt1), .stat_conflict(stat_conflict)
`endif
   );

   always #5 clk = ~clk;

   // Memory the arbiter drives: combinational read, write at the rising edge.
   logic [DW-1:0] mem [64] = '{0: 32'd17, 1: 32'd9, 2: 32'd25, 3: 32'd30, default: '0};
   assign mem_rdata = mem[mem_addr];
   always @(posedge clk) if (mem_write) mem[mem_addr] <= mem_wdata;

   int            n_chk = 0, n_pass = 0;
   int            rr, lk, lcnt, win, sc;
   int            sg [2];
   logic [DW-1:0] rmem [64];
   logic          erv [2];
   logic [DW-1:0] erd [2];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   // Called at a falling edge with inputs already driven; checks this cycle and advances the model.
   task automatic step();
      logic          r [2], w [2], l [2];
      logic [AW-1:0] a [2];
      logic [DW-1:0] d [2];
      r[0] = p0_req; w[0] = p0_we; l[0] = p0_lock; a[0] = p0_addr; d[0] = p0_wdata;
      r[1] = p1_req; w[1] = p1_we; l[1] = p1_lock; a[1] = p1_addr; d[1] = p1_wdata;
      #1;
      if (lk >= 0 && r[lk]) win = lk;
      else if (r[0] && r[1]) win = rr;
      else if (r[0]) win = 0;
      else if (r[1]) win = 1;
      else win = -1;
      chk("p0_gnt", 32'(p0_gnt), 32'(win == 0));
      chk("p1_gnt", 32'(p1_gnt), 32'(win == 1));
      chk("mem_addr", 32'(mem_addr), win < 0 ? 0 : 32'(a[win]));
      chk("mem_wdata", mem_wdata, win < 0 ? 0 : d[win]);
      chk("mem_read", 32'(mem_read), 32'(win >= 0 && !w[win]));
      chk("mem_write", 32'(mem_write), 32'(win >= 0 && w[win]));
      chk("p0_rvalid", 32'(p0_rvalid), 32'(erv[0]));
      chk("p1_rvalid", 32'(p1_rvalid), 32'(erv[1]));
      chk("p0_rdata", p0_rdata, erd[0]);
      chk("p1_rdata", p1_rdata, erd[1]);
      if (r[0] && r[1] && sc < 65535) sc++;
      erv[0] = 0;
      erv[1] = 0;
      if (win >= 0) begin
         if (sg[win] < 65535) sg[win]++;
         if (w[win]) rmem[a[win]] = d[win];
         else begin
            erv[win] = 1;
            erd[win] = rmem[a[win]];
         end
      end
      if (lk >= 0 && r[lk]) begin
         lcnt++;
         if (!l[lk] || lcnt >= LM) begin
            lk = -1;
            rr = 1 - win;
         end
      end else begin
         lk = -1;
         if (win >= 0) begin
            rr = 1 - win;
            if (l[win]) begin
               lk = win;
               lcnt = 1;
               if (lcnt >= LM) lk = -1;
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_p0_rvalid", 32'(p0_rvalid), 0);
      chk("rst_p1_rvalid", 32'(p1_rvalid), 0);
      chk("rst_p0_rdata", p0_rdata, 0);
      chk("rst_p1_rdata", p1_rdata, 0);
      rr = 0; lk = -1; lcnt = 0; sc = 0; sg[0] = 0; sg[1] = 0;
      erv[0] = 0; erv[1] = 0; erd[0] = '0; erd[1] = '0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic drive(input logic r0, w0, l0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                        input logic r1, w1, l1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
      p0_req = r0; p0_we = w0; p0_lock = l0; p0_addr = a0; p0_wdata = d0;
      p1_req = r1; p1_we = w1; p1_lock = l1; p1_addr = a1; p1_wdata = d1;
   endtask

   task automatic rnd(output logic r, w, l, output logic [AW-1:0] a, output logic [DW-1:0] d);
      r = $urandom_range(0, 3) != 0;
      w = 1'($urandom);
      l = $urandom_range(0, 3) == 0;
      a = AW'($urandom_range(0, 7));
      d = $urandom;
   endtask

   initial begin
      for (int i = 0; i < 64; i++) rmem[i] = '0;
      rmem[0] = 17; rmem[1] = 9; rmem[2] = 25; rmem[3] = 30;
      win = -1;
      @(negedge clk);
      do_reset();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      chk("idle_mem_addr", 32'(mem_addr), 0);
      chk("idle_mem_read", 32'(mem_read), 0);
      step();
      // p0 alone reads address 2
      drive(1, 0, 0, 2, 0, 0, 0, 0, 0, 0);
      #1 chk("solo_gnt", 32'(p0_gnt), 1);
      step();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      chk("solo_rvalid", 32'(p0_rvalid), 1);
      chk("solo_rdata", p0_rdata, 25);
      chk("solo_p1_rvalid", 32'(p1_rvalid), 0);
      step();
      // Both read every cycle from reset: grants alternate starting with p0
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drive(1, 0, 0, 0, 0, 1, 0, 0, 1, 0);
         #1 chk("alt_p0_gnt", 32'(p0_gnt), 32'(i % 2 == 0));
         step();
      end
      chk("alt_p0_rdata", p0_rdata, 17);
      chk("alt_p1_rdata", p1_rdata, 9);
      // p1 write wins, then p0's held read of the same address sees it
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step();
      drive(1, 0, 0, 3, 0, 1, 1, 0, 3, 32'hDEAD);
      #1 chk("raw_p1_gnt", 32'(p1_gnt), 1);
      step();
      drive(1, 0, 0, 3, 0, 0, 0, 0, 0, 0);
      step();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1 chk("raw_p0_rdata", p0_rdata, 32'hDEAD);
      step();
      // p1 locks while p0 requests continuously: LM p1 grants, then p0
      do_reset();
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step();
      for (int i = 0; i < LM + 2; i++) begin
         drive(1, 0, 0, 0, 0, 1, 0, 1, 0, 0);
         #1 chk("lock_p1_gnt", 32'(p1_gnt), 32'(i != LM));
         step();
      end
      // Now in LOCK1 with a p1 read pending: reset clears it, then p0 is favoured
      chk("pre_rst_p1_rvalid", 32'(p1_rvalid), 1);
      do_reset();
      drive(1, 0, 0, 1, 0, 1, 0, 0, 2, 0);
      #1 chk("post_rst_p0_gnt", 32'(p0_gnt), 1);
      step();
      // Ten conflicting cycles from reset
      do_reset();
      for (int i = 0; i < 10; i++) begin
         drive(1, 0, 0, 0, 0, 1, 0, 0, 1, 0);
         step();
      end
`ifdef DMEM_ARB_STATS_EN
      chk("stat_conflict", 32'(stat_conflict), 10);
      chk("stat_gnt0", 32'(stat_gnt0), 5);
      chk("stat_gnt1", 32'(stat_gnt1), 5);
`endif
      // Random traffic; a request not yet granted is held unchanged
      for (int i = 0; i < 1500; i++) begin
         if (!(p0_req && win != 0)) rnd(p0_req, p0_we, p0_lock, p0_addr, p0_wdata);
         if (!(p1_req && win != 1)) rnd(p1_req, p1_we, p1_lock, p1_addr, p1_wdata);
         step();
      end
`ifdef DMEM_ARB_STATS_EN
      chk("rnd_stat_conflict", 32'(stat_conflict), 32'(sc));
      chk("rnd_stat_gnt0", 32'(stat_gnt0), 32'(sg[0]));
      chk("rnd_stat_gnt1", 32'(stat_gnt1), 32'(sg[1]));
`endif
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
